// File: rtl/mc_mem_responder_pkg.sv
// Shared types and defaults for the accumulator-core memory responder.
// State encoding is fixed so the boot FSM can be probed by number.
package mc_mem_responder_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int MAX_LEN    = 32;

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

endpackage

// File: rtl/mc_boot_loader.sv
// Boot FSM: zero-fills memory, then takes a length/data/checksum byte
// stream over valid/ready and releases the core only on a good image.
module mc_boot_loader
    import mc_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              reload,
    output logic              ld_ready,
    output logic              cpu_rst,
    output logic              load_err,
    output logic              run,
    output logic              restart,
    output logic              clr_we,
    output logic              prom_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] prom_wdata
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_W);
    localparam logic [DATA_W-1:0] LEN_MAX = DATA_W'(MAX_LEN);

    state_e            state_q, state_d;
    logic [PW-1:0]     clr_idx_q, clr_idx_d;
    logic [PW-1:0]     len_q, len_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
    logic              accept;
    logic [DATA_W-1:0] chk_sum;

    assign ld_ready = (state_q == ST_LEN) || (state_q == ST_DATA)
                   || (state_q == ST_CHECK);
    assign cpu_rst  = (state_q != ST_RUN);
    assign run      = (state_q == ST_RUN);
    assign load_err = err_q;
    assign accept   = ld_valid && ld_ready;
    assign restart  = reload && (state_q != ST_CLR);
    assign chk_sum  = sum_q + ld_data;

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        len_d      = len_q;
        wptr_d     = wptr_q;
        sum_d      = sum_q;
        err_d      = err_q;
        clr_we     = 1'b0;
        prom_we    = 1'b0;
        wr_addr    = wptr_q[ADDR_W-1:0];
        prom_wdata = ld_data;
        unique case (state_q)
            ST_CLR: begin
                clr_we     = 1'b1;
                prom_we    = 1'b1;
                wr_addr    = clr_idx_q[ADDR_W-1:0];
                prom_wdata = '0;
                clr_idx_d  = clr_idx_q + 1'b1;
                if (clr_idx_q == DEPTH - 1'b1) begin
                    state_d   = ST_LEN;
                    clr_idx_d = '0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (ld_data == '0 || ld_data > LEN_MAX) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        len_d   = ld_data[PW-1:0];
                        wptr_d  = '0;
                        sum_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    prom_we = 1'b1;
                    sum_d   = chk_sum;
                    wptr_d  = wptr_q + 1'b1;
                    if (wptr_q + 1'b1 == len_q) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (chk_sum == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN, ST_ERR: begin
            end
            default: state_d = ST_CLR;
        endcase
        // A restart drops any byte accepted in the same cycle.
        if (restart) begin
            state_d   = ST_CLR;
            clr_idx_d = '0;
            err_d     = 1'b0;
            prom_we   = 1'b0;
            clr_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLR;
            clr_idx_q <= '0;
            len_q     <= '0;
            wptr_q    <= '0;
            sum_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            len_q     <= len_d;
            wptr_q    <= wptr_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/mc_mem_responder.sv
// Program ROM, data RAM and fetch counter for the accumulator core,
// with the boot loader owning the program write port.
module mc_mem_responder
    import mc_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] prom_addr_in,
    output logic [DATA_W-1:0] prom_data_out,
    input  logic              rd,
    input  logic              wr,
    input  logic              inst_ld,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              reload,
    output logic              cpu_rst,
    output logic              load_err,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] prom_q [DEPTH];
    logic [DATA_W-1:0] ram_q  [DEPTH];
    logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

    logic              run;
    logic              restart;
    logic              clr_we;
    logic              prom_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] prom_wdata;

    mc_boot_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .reload     (reload),
        .ld_ready   (ld_ready),
        .cpu_rst    (cpu_rst),
        .load_err   (load_err),
        .run        (run),
        .restart    (restart),
        .clr_we     (clr_we),
        .prom_we    (prom_we),
        .wr_addr    (wr_addr),
        .prom_wdata (prom_wdata)
    );

    always_ff @(posedge clk) begin
        if (prom_we) prom_q[wr_addr] <= prom_wdata;
        if (clr_we) begin
            ram_q[wr_addr] <= '0;
        end else if (wr && run) begin
            ram_q[mem_addr_in] <= mem_data_in;
        end
    end

    assign prom_data_out = prom_q[prom_addr_in];
    assign mem_data_out  = rd ? ram_q[mem_addr_in] : '0;
    assign fetch_cnt     = fetch_cnt_q;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (restart) begin
            fetch_cnt_d = '0;
        end else if (inst_ld && run && fetch_cnt_q != '1) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) fetch_cnt_q <= '0;
        else       fetch_cnt_q <= fetch_cnt_d;
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed plus randomized bench for mc_mem_responder, with expected
// images and outcomes derived from the boot stream rules.
module tb_mc_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  prom_addr_in;
    logic [7:0]  prom_data_out;
    logic        rd, wr, inst_ld;
    logic [4:0]  mem_addr_in;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        reload;
    logic        cpu_rst;
    logic        load_err;
    logic [15:0] fetch_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    mc_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .prom_addr_in  (prom_addr_in),
        .prom_data_out (prom_data_out),
        .rd            (rd),
        .wr            (wr),
        .inst_ld       (inst_ld),
        .mem_addr_in   (mem_addr_in),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .reload        (reload),
        .cpu_rst       (cpu_rst),
        .load_err      (load_err),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int w;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                ld_valid = 1'b0;
                ld_data  = 8'($urandom);
                tick();
            end
        end
        ld_valid = 1'b1;
        ld_data  = b;
        w = 0;
        while (!ld_ready && w < 64) begin
            tick();
            w++;
        end
        chk("ld_ready_wait", 32'(ld_ready), 32'd1);
        tick();
    endtask

    task automatic load_image(input logic [7:0] img[$], input bit gaps);
        foreach (img[i]) send_byte(img[i], gaps);
        ld_valid = 1'b0;
    endtask

    // Expected program: first n stream bytes after the length, then zeros.
    task automatic check_prom(input string tag, input logic [7:0] img[$],
                              input int n);
        logic [7:0] exp;
        for (int i = 0; i < 32; i++) begin
            prom_addr_in = 5'(i);
            #1;
            exp = (i < n) ? img[i + 1] : 8'h00;
            chk($sformatf("%s prom[%0d]", tag, i), 32'(prom_data_out),
                32'(exp));
        end
    endtask

    task automatic check_ram_zero(input string tag);
        rd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem_addr_in = 5'(i);
            #1;
            chk($sformatf("%s ram[%0d]", tag, i), 32'(mem_data_out), 32'h0);
        end
        rd = 1'b0;
    endtask

    initial begin
        logic [7:0] img[$];
        logic [7:0] good[$];
        logic [7:0] sum;
        int         len;
        int         npulse;
        bit         ok;

        reset = 1'b1;
        prom_addr_in = '0;
        rd = 1'b0; wr = 1'b0; inst_ld = 1'b0;
        mem_addr_in = '0; mem_data_in = '0;
        ld_valid = 1'b0; ld_data = '0; reload = 1'b0;

        repeat (2) tick();
        chk("rst cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst ld_ready", 32'(ld_ready), 32'd0);
        chk("rst load_err", 32'(load_err), 32'd0);
        chk("rst fetch_cnt", 32'(fetch_cnt), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("clr ready c%0d", i), 32'(ld_ready), 32'd0);
            tick();
        end
        chk("len ready", 32'(ld_ready), 32'd1);
        chk("len cpu_rst", 32'(cpu_rst), 32'd1);
        img = {};
        check_prom("boot", img, 0);
        check_ram_zero("boot");

        wr = 1'b1; mem_addr_in = 5'd5; mem_data_in = 8'h77;
        tick();
        wr = 1'b0;

        good = '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
        for (int i = 0; i < 4; i++) send_byte(good[i], 1'b0);
        chk("pre-ck cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(good[4], 1'b0);
        ld_valid = 1'b0;
        chk("run cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run ld_ready", 32'(ld_ready), 32'd0);
        chk("run load_err", 32'(load_err), 32'd0);
        chk("run fetch_cnt", 32'(fetch_cnt), 32'd0);
        check_prom("good", good, 3);

        rd = 1'b1; mem_addr_in = 5'd5;
        #1;
        chk("early wr ignored", 32'(mem_data_out), 32'h00);
        wr = 1'b1; mem_data_in = 8'h5A;
        #1;
        chk("rw old value", 32'(mem_data_out), 32'h00);
        tick();
        wr = 1'b0;
        #1;
        chk("rw new value", 32'(mem_data_out), 32'h5A);
        rd = 1'b0;
        #1;
        chk("rd low zero", 32'(mem_data_out), 32'h00);

        inst_ld = 1'b1;
        repeat (4) tick();
        inst_ld = 1'b0;
        chk("fetch 4", 32'(fetch_cnt), 32'd4);

        pulse_reload();
        chk("reload cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload fetch", 32'(fetch_cnt), 32'd0);
        chk("reload ready", 32'(ld_ready), 32'd0);
        repeat (9) tick();
        pulse_reload();
        repeat (21) tick();
        chk("clr ignore reload 31", 32'(ld_ready), 32'd0);
        tick();
        chk("clr ignore reload 32", 32'(ld_ready), 32'd1);
        check_ram_zero("reclr");

        img = '{8'h03, 8'h10, 8'h20, 8'h30, 8'hA1};
        load_image(img, 1'b0);
        chk("badck load_err", 32'(load_err), 32'd1);
        chk("badck cpu_rst", 32'(cpu_rst), 32'd1);
        chk("badck ready", 32'(ld_ready), 32'd0);
        inst_ld = 1'b1;
        tick();
        inst_ld = 1'b0;
        chk("err no fetch", 32'(fetch_cnt), 32'd0);
        pulse_reload();
        chk("err reload load_err", 32'(load_err), 32'd0);
        load_image(good, 1'b0);
        chk("retry cpu_rst", 32'(cpu_rst), 32'd0);
        chk("retry load_err", 32'(load_err), 32'd0);

        pulse_reload();
        img = '{8'h00};
        load_image(img, 1'b0);
        chk("len00 load_err", 32'(load_err), 32'd1);
        check_prom("len00", img, 0);
        pulse_reload();
        img = '{8'h21};
        load_image(img, 1'b0);
        chk("len21 load_err", 32'(load_err), 32'd1);
        check_prom("len21", img, 0);

        pulse_reload();
        img = '{8'h05, 8'hAA, 8'hBB};
        load_image(img, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid rst ready", 32'(ld_ready), 32'd0);
        chk("mid rst cpu_rst", 32'(cpu_rst), 32'd1);
        repeat (32) tick();
        chk("mid rst len ready", 32'(ld_ready), 32'd1);
        img = {};
        check_prom("mid rst", img, 0);

        for (int it = 0; it < 6; it++) begin
            len = (it == 0) ? 32 : (it == 1) ? 1 : int'($urandom_range(1, 32));
            ok  = (it < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            img = {};
            img.push_back(8'(len));
            sum = 8'h00;
            for (int i = 0; i < len; i++) begin
                img.push_back(8'($urandom));
                sum = sum + img[i + 1];
            end
            if (ok) img.push_back(8'h00 - sum);
            else    img.push_back(8'h00 - sum + 8'($urandom_range(1, 255)));
            pulse_reload();
            load_image(img, 1'b1);
            chk($sformatf("rand%0d cpu_rst", it), 32'(cpu_rst), 32'(!ok));
            chk($sformatf("rand%0d load_err", it), 32'(load_err), 32'(!ok));
            check_prom($sformatf("rand%0d", it), img, len);
            npulse = $urandom_range(0, 5);
            repeat (npulse) begin
                inst_ld = 1'b1;
                tick();
                inst_ld = 1'b0;
                tick();
            end
            chk($sformatf("rand%0d fetch", it), 32'(fetch_cnt),
                ok ? 32'(npulse) : 32'd0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_mem_responder.md
Name: mc_mem_responder

Overview:
Memory-side responder for the 8-bit accumulator core. It serves the core's program-ROM fetch port and its data-memory read/write port (rd/wr/inst_ld, 5-bit address, 8-bit data). It also contains the boot loader, which fills program memory from a byte stream with a valid/ready handshake. The core is held in reset until a checksum-verified image is loaded.

Parameters:
ADDR_W, 5, address width for program and data memory (depth = 2**ADDR_W = 32)
DATA_W, 8, data width
CNT_W, 16, width of the instruction-fetch counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
prom_addr_in  input  ADDR_W  program fetch address from the core's PC
prom_data_out  output  DATA_W  instruction byte to the core's IR
rd  input  1  data read strobe from the core
wr  input  1  data write strobe from the core
inst_ld  input  1  instruction-fetch strobe from the core
mem_addr_in  input  ADDR_W  data address (IR operand field)
mem_data_in  input  DATA_W  write data (the core's accumulator)
mem_data_out  output  DATA_W  read data to the core's MDR
ld_valid  input  1  loader byte valid
ld_data  input  DATA_W  loader byte
ld_ready  output  1  loader byte accepted when ld_valid and ld_ready are both high
reload  input  1  single-cycle pulse that restarts the boot sequence
cpu_rst  output  1  reset drive to the core; high unless state is RUN
load_err  output  1  sticky image error
fetch_cnt  output  CNT_W  count of inst_ld cycles while in RUN

Behaviour:
- Synchronous, active-high reset. Reset values: state=CLR, clr_idx=0, len=0, sum=0, wptr=0, fetch_cnt=0, load_err=0. Outputs follow: cpu_rst=1, ld_ready=0.
- Reset asserted mid-load or mid-run aborts immediately and returns the block to CLR.
- FSM states: CLR, LEN, DATA, CHECK, RUN, ERR.
- CLR:
  - Each cycle writes 0 to ram[clr_idx] and prom[clr_idx], then increments clr_idx.
  - After index 31 has been written (32 cycles), go to LEN with clr_idx=0.
  - ld_ready=0.
- LEN:
  - ld_ready=1.
  - On accept: byte 0 or byte >32 → ERR. Otherwise len=byte, wptr=0, sum=0, go to DATA.
- DATA:
  - ld_ready=1.
  - On accept: prom[wptr]=byte, sum=sum+byte (mod 256), wptr++.
  - After the len-th byte is accepted, go to CHECK.
- CHECK:
  - ld_ready=1.
  - On accept: if (sum+byte) mod 256 == 0, go to RUN. Otherwise go to ERR.
- RUN: ld_ready=0, cpu_rst=0.
- ERR: ld_ready=0, load_err=1, cpu_rst=1. The block stays in ERR until reload or reset.
- Handshake:
  - A byte transfers only on a cycle where ld_valid and ld_ready are both high.
  - ld_data may change freely when ld_valid=0.
  - ld_ready is a combinational decode of the current state.
- reload:
  - Honoured in any state except CLR; it is ignored while in CLR.
  - Next state is CLR and load_err clears.
  - If reload coincides with an accepted byte, reload wins and the byte is dropped.
- Program port:
  - prom_data_out = prom[prom_addr_in], combinational read.
  - Addresses ≥ len read as 0x00; this is guaranteed by the CLR zero-fill.
- Data port:
  - mem_data_out = ram[mem_addr_in] when rd=1, else 0x00; combinational read.
  - Write: ram[mem_addr_in] = mem_data_in on the clock edge where wr=1 and state=RUN.
  - wr outside RUN is ignored.
  - Simultaneous rd and wr to the same address: mem_data_out shows the old value, and the new value is visible from the next cycle.
- fetch_cnt:
  - Increments on each cycle with inst_ld=1 and state=RUN.
  - Saturates at 2**CNT_W-1.
  - Clears on reset or reload.
- Address arithmetic: wptr and clr_idx are ADDR_W+1 bits wide so that completion at 32 is detectable without wrap.

Decomposition:
- Shared package/include holds:
  - state encodings: CLR=0, LEN=1, DATA=2, CHECK=3, RUN=4, ERR=5 (3 bits)
  - MAX_LEN=32
  - ADDR_W and DATA_W defaults
- One natural sub-module, mc_boot_loader: the FSM, handshake, checksum and write-port mux.
- The top level holds both 32x8 arrays, the read muxes and fetch_cnt.

Test Plan:
- Reset, then idle 32 cycles → cpu_rst=1, ld_ready=0 during CLR. Cycle 33: ld_ready=1. Every ram and prom address reads 0x00.
- Stream 03,10,20,30,A0 with ld_valid held high → RUN after the 5th accept, cpu_rst=0. prom[0..2]=10,20,30. prom[3]=00. fetch_cnt=0.
- Same image with checksum A1 → ERR, load_err=1, cpu_rst stays 1. Then reload pulse → CLR, load_err=0, reload succeeds.
- Length byte 00, and separately 21 → ERR on that accept, with no prom write.
- In RUN: wr=1, addr=05, data=5A, then rd=1, addr=05 → mem_data_out=5A next cycle. wr issued before RUN leaves ram[05]=00. Four inst_ld pulses → fetch_cnt=4.
- Toggle ld_valid randomly during load → the prom image matches the byte order and checksum behaviour is unchanged. Reset mid-DATA → returns to CLR and prom is zero-filled again.
